// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and arctangent table for the CORDIC vectoring core.
// The SCALE state exists only when CORDIC_VECTOR_SCALE_EN is defined.
package cordic_pkg;

  localparam int DW       = 64;
  localparam int FRAC     = 44;
  localparam int ITER_MAX = 45;

  typedef logic signed [DW-1:0] fix_t;

  // All constants are signed 20.44 fixed point.
  localparam fix_t PI       = 64'h00003_243F6A8885A;
  localparam fix_t PI2      = 64'h00001_921FB54442D;
  localparam fix_t COEF_DEF = 64'h00000_9B74EDA8436;
  localparam fix_t ONE      = 64'h00001_00000000000;

`ifdef CORDIC_VECTOR_SCALE_EN
  typedef enum logic [2:0] {IDLE, FOLD, CALC, SCALE, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, FOLD, CALC, DONE} state_e;
`endif

  // atan(2^-i) rounded to 20.44; entries 1..44 come from the Taylor series
  // evaluated with 100 fractional bits, entry 0 is pi/4.
  function automatic logic [ITER_MAX-1:0][DW-1:0] build_atan_lut();
    logic [ITER_MAX-1:0][DW-1:0] lut;
    logic [127:0]                acc;
    logic [127:0]                term;
    lut    = '0;
    lut[0] = 64'h00000_C90FDAA2217;
    for (int i = 1; i < ITER_MAX; i++) begin
      acc = '0;
      for (int k = 0; i * (2 * k + 1) <= 100; k++) begin
        term = (128'd1 << (100 - i * (2 * k + 1))) / 128'(2 * k + 1);
        if (k % 2 == 1) acc = acc - term;
        else            acc = acc + term;
      end
      lut[i] = DW'((acc + (128'd1 << (99 - FRAC))) >> (100 - FRAC));
    end
    return lut;
  endfunction

  localparam logic [ITER_MAX-1:0][DW-1:0] ATAN_LUT = build_atan_lut();

  // Accumulated rounding can overshoot +PI by a few LSBs on the negative real axis.
  function automatic fix_t limit_phase(input fix_t z);
    return (z > PI) ? PI : z;
  endfunction

endpackage

// File: rtl/mult_sign.sv
// Signed fixed-point multiplier: a (INT1_I integer bits) times b (INT2_I integer bits)
// giving p with INT3_O integer bits, truncated toward minus infinity.
module mult_sign #(
  parameter int DW     = 64,
  parameter int INT1_I = 20,
  parameter int INT2_I = 20,
  parameter int INT3_O = 20
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] p_o
);

  localparam int SHIFT = (DW - INT1_I) + (DW - INT2_I) - (DW - INT3_O);

  logic signed [2*DW-1:0] prod;

  assign prod = (2*DW)'(a_i) * (2*DW)'(b_i);
  assign p_o  = DW'(prod >>> SHIFT);

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring core: (x, y) in 20.44 -> magnitude and atan2 phase.
// Define CORDIC_VECTOR_SCALE_EN to add the gain-compensation multiply (SCALE state).
module cordic_vector
  import cordic_pkg::*;
#(
  parameter int ITER = 45
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x_i,
  input  logic signed [DW-1:0] y_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] mag_o,
  output logic signed [DW-1:0] phase_o
);

  // Two integer guard bits absorb the CORDIC gain, eight fractional guard bits
  // keep shift truncation noise below the output LSB.
  localparam int GI = 2;
  localparam int GF = 8;
  localparam int IW = DW + GI + GF;

  typedef logic signed [IW-1:0] acc_t;

  state_e     state_q, state_d;
  acc_t       x_q, x_d, y_q, y_d;
  fix_t       z_q, z_d;
  fix_t       mag_q, mag_d, phase_q, phase_d;
  logic [5:0] iter_q, iter_d;
  logic       zero_q, zero_d;
  logic       in_ready_q;

  acc_t x_in, y_in, x_sh, y_sh;
  fix_t atan_i;

  assign x_in   = {{GI{x_i[DW-1]}}, x_i, {GF{1'b0}}};
  assign y_in   = {{GI{y_i[DW-1]}}, y_i, {GF{1'b0}}};
  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;
  assign atan_i = fix_t'(ATAN_LUT[iter_q]);

`ifdef CORDIC_VECTOR_SCALE_EN
  fix_t mag_scaled;

  mult_sign #(
    .DW    (DW),
    .INT1_I(20),
    .INT2_I(20),
    .INT3_O(20)
  ) u_mult (
    .a_i(x_q[GF +: DW]),
    .b_i(COEF_DEF),
    .p_o(mag_scaled)
  );
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    phase_d = phase_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = '0;
          iter_d  = '0;
          zero_d  = (x_i == '0) && (y_i == '0);
          state_d = FOLD;
        end
      end

      FOLD: begin
        if (x_q[IW-1] && !y_q[IW-1]) begin
          x_d = y_q;
          y_d = -x_q;
          z_d = PI2;
        end else if (x_q[IW-1]) begin
          x_d = -y_q;
          y_d = x_q;
          z_d = -PI2;
        end
        state_d = CALC;
      end

      CALC: begin
        if (!y_q[IW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end
        iter_d = iter_q + 6'd1;
        if (iter_q == 6'(ITER - 1)) begin
          iter_d = '0;
`ifdef CORDIC_VECTOR_SCALE_EN
          state_d = SCALE;
`else
          mag_d   = x_d[GF +: DW];
          phase_d = zero_q ? '0 : limit_phase(z_d);
          state_d = DONE;
`endif
        end
      end

`ifdef CORDIC_VECTOR_SCALE_EN
      SCALE: begin
        mag_d   = mag_scaled;
        phase_d = zero_q ? '0 : limit_phase(z_q);
        state_d = DONE;
      end
`endif

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: datapath registers are reset as well, so outputs read zero during reset.
    if (!rstn) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      iter_q     <= '0;
      zero_q     <= 1'b0;
      mag_q      <= '0;
      phase_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      iter_q     <= iter_d;
      zero_q     <= zero_d;
      mag_q      <= mag_d;
      phase_q    <= phase_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign mag_o     = mag_q;
  assign phase_o   = phase_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: directed vector table, random vectors against
// a real-arithmetic model, backpressure and mid-operation reset sequences.
module tb_cordic_vector;

  localparam int ITER = 45;
`ifdef CORDIC_VECTOR_SCALE_EN
  localparam int LAT = ITER + 2;
`else
  localparam int LAT = ITER + 1;
`endif

  localparam real    TWO44   = 17592186044416.0;
  localparam real    PH_TOL  = 1.0 / 1099511627776.0;   // 2^-40 rad
  localparam real    MAG_ABS = 1.0 / 274877906944.0;    // 2^-38
  localparam real    MAG_REL = 1.0 / 4398046511104.0;   // 2^-42, double/coefficient precision
  localparam real    PI_R    = 3.14159265358979323846;
  localparam longint ONE     = 64'sh0000_1000_0000_0000;

  logic               clk       = 1'b0;
  logic               rstn      = 1'b1;
  logic               in_valid  = 1'b0;
  logic               out_ready = 1'b0;
  logic               in_ready;
  logic               out_valid;
  logic signed [63:0] x_i = '0;
  logic signed [63:0] y_i = '0;
  logic signed [63:0] mag_o;
  logic signed [63:0] phase_o;

  always #5 clk = ~clk;

  cordic_vector #(.ITER(ITER)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_i      (x_i),
    .y_i      (y_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag_o    (mag_o),
    .phase_o  (phase_o)
  );

  typedef struct {
    string  name;
    longint x;
    longint y;
    real    mag;
    real    ph;
  } vec_t;

  int  n_checks = 0;
  int  n_pass   = 0;
  real gain     = 1.0;

  function automatic real to_real(input logic signed [63:0] v);
    return real'(v) / TWO44;
  endfunction

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_near(input string name, input logic signed [63:0] act,
                            input real exp, input real tol);
    real err;
    err = to_real(act) - exp;
    if (err < 0.0) err = -err;
    n_checks++;
    if (err <= tol) n_pass++;
    else $display("FAIL %s: got %.15f (0x%h) expected %.15f tol %g",
                  name, to_real(act), act, exp, tol);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check_eq({name, "_ready"}, longint'(in_ready), 1);
  endtask

  // One transaction; with noise set, in_valid stays high with junk operands while busy.
  task automatic run_op(input string name, input longint x, input longint y, input bit noise,
                        output logic signed [63:0] mag, output logic signed [63:0] phase,
                        output int lat);
    wait_ready(name);
    x_i      = x;
    y_i      = y;
    in_valid = 1'b1;
    tick();
    in_valid = noise;
    lat      = 0;
    while (!out_valid && lat < LAT + 20) begin
      if (noise) begin
        x_i = {$urandom(), $urandom()};
        y_i = {$urandom(), $urandom()};
      end
      tick();
      lat++;
    end
    mag       = mag_o;
    phase     = phase_o;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic run_and_check(input string name, input longint x, input longint y,
                               input bit noise, input real true_mag, input real true_ph);
    logic signed [63:0] mag, phase;
    int                 lat;
    real                em;
    run_op(name, x, y, noise, mag, phase, lat);
    em = true_mag * gain;
    check_near({name, "_mag"}, mag, em, MAG_ABS + em * MAG_REL);
    check_near({name, "_phase"}, phase, true_ph, PH_TOL);
    check_eq({name, "_latency"}, lat, LAT);
  endtask

  initial begin
    vec_t               vecs[10];
    logic signed [63:0] mag, phase;
    int                 lat;
    int                 cnt;
    real                pw;

`ifndef CORDIC_VECTOR_SCALE_EN
    pw = 1.0;
    for (int i = 0; i < ITER; i++) begin
      gain = gain * $sqrt(1.0 + pw);
      pw   = pw / 4.0;
    end
`endif

    vecs[0] = '{"pos_real", ONE,          0,             1.0,                 0.0};
    vecs[1] = '{"pos_imag", 0,            ONE,           1.0,                 PI_R / 2.0};
    vecs[2] = '{"q4_diag",  ONE,          -ONE,          1.4142135623730951,  -PI_R / 4.0};
    vecs[3] = '{"neg_real", -ONE,         0,             1.0,                 PI_R};
    vecs[4] = '{"q3_diag",  -ONE,         -ONE,          1.4142135623730951,  -3.0 * PI_R / 4.0};
    vecs[5] = '{"q2_345",   -3 * ONE,     4 * ONE,       5.0,                 2.214297435588181};
    vecs[6] = '{"neg_imag", 0,            -2 * ONE,      2.0,                 -PI_R / 2.0};
    vecs[7] = '{"big_q4",   100000 * ONE, -100000 * ONE, 141421.35623730951,  -PI_R / 4.0};
    vecs[8] = '{"q1_small", ONE / 2,      ONE / 4,       0.5590169943749474,  0.4636476090008061};
    vecs[9] = '{"near_mpi", -ONE,         -1,            1.0,                 -PI_R};

    // Reset state.
    #2 rstn = 1'b0;
    repeat (3) tick();
    check_eq("rst_in_ready", longint'(in_ready), 0);
    check_eq("rst_out_valid", longint'(out_valid), 0);
    check_eq("rst_mag", mag_o, 0);
    check_eq("rst_phase", phase_o, 0);
    rstn = 1'b1;
    tick();
    check_eq("rst_release_ready", longint'(in_ready), 1);

    // Directed table.
    foreach (vecs[i])
      run_and_check(vecs[i].name, vecs[i].x, vecs[i].y, (i % 4) == 1, vecs[i].mag, vecs[i].ph);

    // Zero vector: exact zero outputs and nominal latency.
    run_op("zero", 0, 0, 1'b0, mag, phase, lat);
    check_eq("zero_mag", mag, 0);
    check_eq("zero_phase", phase, 0);
    check_eq("zero_latency", lat, LAT);

    // Random vectors against the real-arithmetic model.
    for (int r = 0; r < 30; r++) begin
      real    xr, yr;
      int     e;
      longint xf, yf;
      e  = int'($urandom_range(17, 0)) - 1;
      xr = (real'($urandom_range(2000000, 0)) / 1000000.0 - 1.0) * (2.0 ** e);
      yr = (real'($urandom_range(2000000, 0)) / 1000000.0 - 1.0) * (2.0 ** e);
      if ($sqrt(xr * xr + yr * yr) < 0.5) xr = (xr < 0.0) ? -0.75 : 0.75;
      xf = longint'(xr * TWO44);
      yf = longint'(yr * TWO44);
      xr = real'(xf) / TWO44;
      yr = real'(yf) / TWO44;
      run_and_check($sformatf("rand%0d", r), xf, yf, (r % 3) == 0,
                    $sqrt(xr * xr + yr * yr), $atan2(yr, xr));
    end

    // Backpressure: result held, input side closed, in_valid pulses ignored.
    wait_ready("bp");
    x_i      = 3 * ONE;
    y_i      = 4 * ONE;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < LAT + 20) begin
      tick();
      lat++;
    end
    check_eq("bp_latency", lat, LAT);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2) == 0;
      x_i      = {$urandom(), $urandom()};
      y_i      = {$urandom(), $urandom()};
      check_eq($sformatf("bp_valid%0d", k), longint'(out_valid), 1);
      check_eq($sformatf("bp_ready%0d", k), longint'(in_ready), 0);
      check_near($sformatf("bp_mag%0d", k), mag_o, 5.0 * gain, MAG_ABS + 5.0 * gain * MAG_REL);
      check_near($sformatf("bp_phase%0d", k), phase_o, 0.9272952180016122, PH_TOL);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_release_ready", longint'(in_ready), 1);
    check_eq("bp_release_valid", longint'(out_valid), 0);

    // Reset during CALC iteration 20 aborts the operation.
    wait_ready("abort");
    x_i      = 2 * ONE;
    y_i      = -ONE;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (21) tick();
    rstn = 1'b0;
    #1;
    check_eq("abort_in_ready", longint'(in_ready), 0);
    check_eq("abort_out_valid", longint'(out_valid), 0);
    check_eq("abort_mag", mag_o, 0);
    check_eq("abort_phase", phase_o, 0);
    tick();
    tick();
    rstn = 1'b1;
    check_eq("abort_ready_before_edge", longint'(in_ready), 0);
    tick();
    check_eq("abort_ready_first_edge", longint'(in_ready), 1);
    cnt = 0;
    for (int c = 0; c < LAT + 10; c++) begin
      if (out_valid) cnt++;
      tick();
    end
    check_eq("abort_no_result", cnt, 0);
    run_and_check("after_abort", 2 * ONE, ONE, 1'b0, 2.23606797749979, 0.4636476090008061);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
